// File: rtl/onehot_serializer_if.sv
// Handshake bundle between the one-hot serializer and its surroundings.
// master: the serializer side (drives the grant and busy).
// slave:  the requester/consumer side (drives requests and ready).
interface onehot_serializer_if #(
  parameter int n = 3
);
  localparam int W = 2 ** n;

  logic [W-1:0] req_in;
  logic         req_load;
  logic [W-1:0] oh_out;
  logic         oh_valid;
  logic         oh_ready;
  logic         busy;

  modport master (
    input  req_in,
    input  req_load,
    input  oh_ready,
    output oh_out,
    output oh_valid,
    output busy
  );

  modport slave (
    output req_in,
    output req_load,
    output oh_ready,
    input  oh_out,
    input  oh_valid,
    input  busy
  );
endinterface

// File: rtl/onehot_serializer.sv
// One-hot serializer: collects a multi-bit request set and offers it one bit
// at a time, round-robin, as a strictly one-hot word under valid/ready.
// The downstream index encoder ORs indices of set bits, so the grant must be
// one-hot whenever oh_valid is high; the grant never changes while stalled.
module onehot_serializer #(
  parameter int n = 3
) (
  input logic                clk,
  input logic                rst,
  onehot_serializer_if.master bus
);
  localparam int W = 2 ** n;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OFFER = 1'b1;

  // First set bit of v at index >= p, scanning upward and wrapping W-1 -> 0.
  // Returns all-zero when v is empty.
  function automatic logic [W-1:0] rr_pick(input logic [W-1:0] v,
                                           input logic [n-1:0] p);
    logic [W-1:0] g;
    logic         found;
    logic [n-1:0] k;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < W; i++) begin
      k = p + n'(i);  // n-bit sum wraps naturally
      if (!found && v[k]) begin
        g[k]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  // Index of a one-hot word (OR of the indices of all set bits).
  function automatic logic [n-1:0] oh_index(input logic [W-1:0] v);
    logic [n-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (v[i]) r = r | n'(i);
    end
    return r;
  endfunction

  logic [0:0]   state;
  logic [W-1:0] pending;
  logic [n-1:0] ptr;
  logic [W-1:0] grant;
  logic         grant_valid;

  logic         acc;
  logic [W-1:0] clr;
  logic [W-1:0] pend_nx;
  logic [n-1:0] ptr_nx;
  logic [W-1:0] pick;

  // Next-state terms: accepted bit cleared, new requests set (set wins),
  // pointer advanced past an accepted grant, next round-robin candidate.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    acc     = (state == OFFER) && bus.oh_ready;
    clr     = acc ? grant : '0;
    pend_nx = (pending & ~clr) | (bus.req_load ? bus.req_in : '0);
    ptr_nx  = acc ? (oh_index(grant) + n'(1)) : ptr;
    pick    = rr_pick(pend_nx, ptr_nx);
  end

  // Pending set, pointer and offer register; the offer only changes on
  // leaving IDLE or on an accept, never while the consumer stalls.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= '0;
      ptr         <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
    end else begin
      pending <= pend_nx;
      ptr     <= ptr_nx;
      case (state)
        IDLE: begin
          if (|pend_nx) begin
            grant       <= pick;
            grant_valid <= 1'b1;
            state       <= OFFER;
          end
        end
        OFFER: begin
          if (acc) begin
            if (|pick) begin
              grant <= pick;
            end else begin
              grant       <= '0;
              grant_valid <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: begin
          grant       <= '0;
          grant_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.oh_out   = grant;
  assign bus.oh_valid = grant_valid;
  assign bus.busy     = |pending;
endmodule

// File: tb/tb_onehot_serializer.sv
// Self-checking bench for onehot_serializer (n=3, W=8).
// Directed tests queue the expected grant sequence; the random test keeps a
// queue of outstanding request bits that each accepted grant must retire.
module tb_onehot_serializer;
  localparam int N = 3;
  localparam int W = 2 ** N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  onehot_serializer_if #(.n(N)) bus ();

  onehot_serializer #(.n(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];   // expected grants, directed tests
  logic [W-1:0] req_q[$];   // outstanding request bits, random test
  logic [W-1:0] model_pend;
  bit           rand_mode;
  int           grants;
  int           requests;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: account for the accept/load seen before the edge, then check
  // the outputs that follow it.
  task automatic tick();
    logic         acc;
    logic         pre_valid;
    logic [W-1:0] g;
    logic [W-1:0] fresh;
    logic [N-1:0] enc_idx;
    int           hit;
    pre_valid = bus.oh_valid;
    acc       = bus.oh_valid && bus.oh_ready;
    g         = bus.oh_out;
    if (acc) begin
      grants++;
      if (rand_mode) begin
        hit = -1;
        foreach (req_q[i]) if (hit < 0 && req_q[i] == g) hit = i;
        if (hit < 0) check("grant_requested", g, 0);
        else req_q.delete(hit);
      end else if (exp_q.size() == 0) begin
        check("unexpected_grant", g, 0);
      end else begin
        check("grant", g, exp_q.pop_front());
      end
      model_pend &= ~g;
    end
    if (bus.req_load) begin
      fresh = bus.req_in & ~model_pend;
      requests += $countones(fresh);
      for (int i = 0; i < W; i++) if (fresh[i]) req_q.push_back(W'(1) << i);
      model_pend |= bus.req_in;
    end
    @(posedge clk);
    #1;
    check("busy", bus.busy, |model_pend);
    if (pre_valid && !acc) check("stall_hold", bus.oh_out, g);
    enc_idx = '0;
    for (int i = 0; i < W; i++) if (bus.oh_out[i]) enc_idx = enc_idx | N'(i);
    if (bus.oh_valid) begin
      check("enc_index", bus.oh_out, W'(1) << enc_idx);
      check("in_pending", |(bus.oh_out & model_pend), 1);
    end else begin
      check("idle_zero", bus.oh_out, 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_oh_out", bus.oh_out, 0);
    check("rst_oh_valid", bus.oh_valid, 0);
    check("rst_busy", bus.busy, 0);
    model_pend = '0;
    exp_q.delete();
    req_q.delete();
    bus.req_load = 1'b0;
    bus.req_in   = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    bus.req_load = 1'b0;
    bus.oh_ready = 1'b1;
    while ((bus.oh_valid || bus.busy) && k < budget) begin
      tick();
      k++;
    end
    check("drain_done", {bus.oh_valid, bus.busy}, 0);
  endtask

  initial begin
    rand_mode    = 1'b0;
    grants       = 0;
    requests     = 0;
    model_pend   = '0;
    bus.req_in   = '0;
    bus.req_load = 1'b0;
    bus.oh_ready = 1'b0;
    rst          = 1'b1;
    #2;
    do_reset();

    // Multi-bit load drains in index order, one grant per cycle.
    bus.req_in = 8'b1010_0110; bus.req_load = 1'b1; bus.oh_ready = 1'b1;
    exp_q.push_back(8'h02); exp_q.push_back(8'h04);
    exp_q.push_back(8'h20); exp_q.push_back(8'h80);
    tick();
    check("latency_valid", bus.oh_valid, 1);
    bus.req_load = 1'b0;
    repeat (4) tick();
    check("t2_valid_drop", bus.oh_valid, 0);
    check("t2_busy", bus.busy, 0);
    check("t2_queue_empty", exp_q.size(), 0);

    // Stalled offer holds even when a new request arrives.
    bus.req_in = 8'h02; bus.req_load = 1'b1; bus.oh_ready = 1'b0;
    tick();
    for (int s = 0; s < 5; s++) begin
      bus.req_load = (s == 2);
      bus.req_in   = 8'h01;
      tick();
      check("t3_offer", bus.oh_out, 8'h02);
    end
    bus.req_load = 1'b0; bus.oh_ready = 1'b1;
    exp_q.push_back(8'h02); exp_q.push_back(8'h01);
    repeat (2) tick();
    check("t3_idle", bus.oh_valid, 0);
    check("t3_queue_empty", exp_q.size(), 0);

    // Reset in the middle of an offer drops everything.
    bus.req_in = 8'h3C; bus.req_load = 1'b1; bus.oh_ready = 1'b0;
    tick();
    check("t1_offer_up", bus.oh_valid, 1);
    do_reset();
    bus.oh_ready = 1'b1;
    repeat (3) begin
      tick();
      check("t1_no_grant", bus.oh_valid, 0);
    end

    // Round-robin fairness with a permanently loaded 0x81.
    bus.req_in = 8'h81; bus.req_load = 1'b1; bus.oh_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h80);
    end
    repeat (5) tick();
    bus.req_load = 1'b0;
    repeat (2) tick();
    check("t4_idle", bus.oh_valid, 0);
    check("t4_queue_empty", exp_q.size(), 0);

    // Accept of 0x04 with a simultaneous re-request of 0x04.
    bus.req_in = 8'h54; bus.req_load = 1'b1; bus.oh_ready = 1'b1;
    exp_q.push_back(8'h04); exp_q.push_back(8'h10);
    exp_q.push_back(8'h40); exp_q.push_back(8'h04);
    tick();
    bus.req_in = 8'h04;
    tick();
    bus.req_load = 1'b0;
    repeat (3) tick();
    check("t5_idle", bus.oh_valid, 0);
    check("t5_busy", bus.busy, 0);
    check("t5_queue_empty", exp_q.size(), 0);

    // Random request streams, random back-pressure.
    rand_mode = 1'b1;
    grants    = 0;
    requests  = 0;
    req_q.delete();
    for (int c = 0; c < 400; c++) begin
      bus.req_load = ($urandom_range(0, 2) == 0);
      bus.req_in   = W'($urandom);
      bus.oh_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain(40);
    check("t6_grants_eq_requests", grants, requests);
    check("t6_outstanding", req_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
